// File: rtl/sudoku_pkg.sv
// Shared definitions for the Sudoku display path.
//   DIGIT_W / SEG_W      : cell value width and seven-segment pattern width
//   DIGIT_BLANK/DIGIT_MAX: value range of a cell (0 = blank, 1..9 = digit)
//   SEG_BLANK            : active-low pattern with every segment off
//   action_e             : per-cycle action chosen by the cursor/edit controller
//   digitSanitize/digitInc/digitDec : cell value helpers
package sudoku_pkg;

  localparam int DIGIT_W = 4;
  localparam int SEG_W   = 7;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [SEG_W-1:0]   seg_t;

  localparam digit_t DIGIT_BLANK = 4'd0;
  localparam digit_t DIGIT_MAX   = 4'd9;
  localparam seg_t   SEG_BLANK   = 7'h7F;

  typedef enum logic [1:0] {
    ACT_NONE,
    ACT_LOAD,
    ACT_MOVE,
    ACT_EDIT
  } action_e;

  // Out-of-range puzzle values are treated as blank cells.
  function automatic digit_t digitSanitize(input digit_t v);
    return (v > DIGIT_MAX) ? DIGIT_BLANK : v;
  endfunction

  // blank -> 1 -> ... -> 9 -> blank
  function automatic digit_t digitInc(input digit_t v);
    return (v >= DIGIT_MAX) ? DIGIT_BLANK : v + 4'd1;
  endfunction

  // blank -> 9 -> ... -> 1 -> blank
  function automatic digit_t digitDec(input digit_t v);
    return (v == DIGIT_BLANK) ? DIGIT_MAX : v - 4'd1;
  endfunction

endpackage

// File: rtl/digit_to_segments.sv
// Combinational cell value to seven-segment decoder.
//   digit    : cell value, 0 = blank, 1..9 = digit
//   segments : active-low pattern, segment a in bit 0 .. segment g in bit 6;
//              blank and any out-of-range value show all segments off
module digit_to_segments
  import sudoku_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      4'd1:    segments = 7'h79;
      4'd2:    segments = 7'h24;
      4'd3:    segments = 7'h30;
      4'd4:    segments = 7'h19;
      4'd5:    segments = 7'h12;
      4'd6:    segments = 7'h02;
      4'd7:    segments = 7'h78;
      4'd8:    segments = 7'h00;
      4'd9:    segments = 7'h10;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digit_select_ctrl.sv
// Cursor-and-edit controller for the row of seven-segment cells.
// Holds each cell value and lock, moves a one-hot cursor on button presses,
// edits the selected cell and produces registered segment patterns.
//   clk, rst        : clock, asynchronous active-low reset
//   btn_left/right  : move cursor toward digit 0 / NUM_DIGITS-1 (with wrap)
//   btn_inc/dec     : cycle the selected cell blank->1..9->blank / reverse
//   load            : strobe loading load_values / load_lock, cursor home
//   digit_selected  : one-hot cursor
//   digit_segments  : active-low segment pattern per cell (7 bits each)
//   cell_values     : current cell values (4 bits each)
// Build option: define CURSOR_SKIP_LOCKED_EN to make the cursor skip locked
// cells and land on the lowest unlocked cell after a load.
module digit_select_ctrl
  import sudoku_pkg::*;
#(
  parameter int NUM_DIGITS = 4
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_values,
  input  logic [NUM_DIGITS-1:0]         load_lock,
  output logic [NUM_DIGITS-1:0]         digit_selected,
  output logic [SEG_W*NUM_DIGITS-1:0]   digit_segments,
  output logic [DIGIT_W*NUM_DIGITS-1:0] cell_values
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Previous button levels, packed {dec, inc, right, left}.
  logic [3:0] btnPrev;
  logic       leftEdge, rightEdge, incEdge, decEdge;

  logic [IDX_W-1:0] cursorReg, cursorNext;
  logic [IDX_W-1:0] rightTarget, leftTarget, loadCursor;
  logic [NUM_DIGITS-1:0] lockReg, lockNext;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] cellReg, cellNext;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]   segReg, segNext;

  action_e action;

  always_comb begin
    leftEdge  = btn_left  & ~btnPrev[0];
    rightEdge = btn_right & ~btnPrev[1];
    incEdge   = btn_inc   & ~btnPrev[2];
    decEdge   = btn_dec   & ~btnPrev[3];
  end

  // Any move edge claims the cycle, even when left and right cancel out.
  always_comb begin
    if (load)
      action = ACT_LOAD;
    else if (leftEdge | rightEdge)
      action = ACT_MOVE;
    else if (incEdge | decEdge)
      action = ACT_EDIT;
    else
      action = ACT_NONE;
  end

`ifdef CURSOR_SKIP_LOCKED_EN
  function automatic logic [IDX_W-1:0] wrapIdx(input int unsigned v);
    return IDX_W'(v % NUM_DIGITS);
  endfunction

  logic rightFound, leftFound;

  // Scan outward from the cursor for the nearest unlocked cell each way;
  // with no unlocked cell anywhere else the cursor stays put.
  always_comb begin
    rightTarget = cursorReg;
    leftTarget  = cursorReg;
    rightFound  = 1'b0;
    leftFound   = 1'b0;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      if (!rightFound && !lockReg[wrapIdx(32'(cursorReg) + k)]) begin
        rightTarget = wrapIdx(32'(cursorReg) + k);
        rightFound  = 1'b1;
      end
      if (!leftFound && !lockReg[wrapIdx(32'(cursorReg) + NUM_DIGITS - k)]) begin
        leftTarget = wrapIdx(32'(cursorReg) + NUM_DIGITS - k);
        leftFound  = 1'b1;
      end
    end
  end

  // Descending scan so the lowest unlocked index wins; all locked -> 0.
  always_comb begin
    loadCursor = '0;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      if (!load_lock[k-1])
        loadCursor = IDX_W'(k - 1);
    end
  end
`else
  always_comb begin
    rightTarget = (cursorReg == LAST_IDX) ? '0 : cursorReg + 1'b1;
    leftTarget  = (cursorReg == '0) ? LAST_IDX : cursorReg - 1'b1;
    loadCursor  = '0;
  end
`endif

  always_comb begin
    cellNext   = cellReg;
    lockNext   = lockReg;
    cursorNext = cursorReg;
    case (action)
      ACT_LOAD: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
          cellNext[i] = digitSanitize(load_values[i*DIGIT_W +: DIGIT_W]);
        lockNext   = load_lock;
        cursorNext = loadCursor;
      end
      ACT_MOVE: begin
        if (rightEdge && !leftEdge)
          cursorNext = rightTarget;
        else if (leftEdge && !rightEdge)
          cursorNext = leftTarget;
      end
      ACT_EDIT: begin
        if ((incEdge ^ decEdge) && !lockReg[cursorReg])
          cellNext[cursorReg] = incEdge ? digitInc(cellReg[cursorReg])
                                        : digitDec(cellReg[cursorReg]);
      end
      default: ;
    endcase
  end

  // Decode from next-state values so the registered pattern tracks the
  // registered cell value in the same cycle.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gDecode
    digit_to_segments uDecode (
      .digit    (cellNext[g]),
      .segments (segNext[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btnPrev   <= '0;
      cursorReg <= '0;
      lockReg   <= '0;
      cellReg   <= '0;
      segReg    <= '1;
    end else begin
      btnPrev   <= {btn_dec, btn_inc, btn_right, btn_left};
      cursorReg <= cursorNext;
      lockReg   <= lockNext;
      cellReg   <= cellNext;
      segReg    <= segNext;
    end
  end

  always_comb begin
    digit_selected = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      digit_selected[i] = (cursorReg == IDX_W'(i));
  end

  assign cell_values    = cellReg;
  assign digit_segments = segReg;

endmodule

// File: tb/tb_digit_select_ctrl.sv
module tb_digit_select_ctrl;

  localparam int N = 4;

  localparam logic [3:0] NONE = 4'b0000;
  localparam logic [3:0] L    = 4'b0001;
  localparam logic [3:0] R    = 4'b0010;
  localparam logic [3:0] I    = 4'b0100;
  localparam logic [3:0] D    = 4'b1000;

`ifdef CURSOR_SKIP_LOCKED_EN
  localparam logic [3:0] RIGHT_FROM0 = 4'b0100;
`else
  localparam logic [3:0] RIGHT_FROM0 = 4'b0010;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic load = 1'b0;
  logic [4*N-1:0] load_values = '0;
  logic [N-1:0]   load_lock = '0;
  logic [N-1:0]   digit_selected;
  logic [7*N-1:0] digit_segments;
  logic [4*N-1:0] cell_values;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic done = 1'b0;

  typedef struct {
    int          due;
    logic [3:0]  sel;
    logic [15:0] cells;
    string       name;
  } exp_t;

  exp_t sb[$];

  digit_select_ctrl #(.NUM_DIGITS(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_inc        (btn_inc),
    .btn_dec        (btn_dec),
    .load           (load),
    .load_values    (load_values),
    .load_lock      (load_lock),
    .digit_selected (digit_selected),
    .digit_segments (digit_segments),
    .cell_values    (cell_values)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] segOf(input logic [3:0] v);
    case (v)
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] segsOf(input logic [15:0] c);
    logic [27:0] s;
    for (int i = 0; i < 4; i++) s[7*i +: 7] = segOf(c[4*i +: 4]);
    return s;
  endfunction

  // Expected state after the next rising edge.
  task automatic expectNext(input logic [3:0] sel, input logic [15:0] cells,
                            input string name);
    sb.push_back('{due: cyc + 1, sel: sel, cells: cells, name: name});
  endtask

  task automatic loadStep(input logic [3:0] btns, input logic [15:0] lv,
                          input logic [3:0] lk, input logic [3:0] sel,
                          input logic [15:0] cells, input string name);
    @(negedge clk);
    {btn_dec, btn_inc, btn_right, btn_left} = btns;
    load = 1'b1;
    load_values = lv;
    load_lock = lk;
    expectNext(sel, cells, name);
  endtask

  task automatic step(input logic [3:0] btns, input logic [3:0] sel,
                      input logic [15:0] cells, input string name);
    @(negedge clk);
    {btn_dec, btn_inc, btn_right, btn_left} = btns;
    load = 1'b0;
    expectNext(sel, cells, name);
  endtask

  task automatic press(input logic [3:0] btns, input logic [3:0] sel,
                       input logic [15:0] cells, input string name);
    step(btns, sel, cells, name);
    step(NONE, sel, cells, {name, "_release"});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (digit_selected !== e.sel) begin
        errors++;
        $display("FAIL %s sel: got %b required %b (cycle %0d)", e.name, digit_selected, e.sel, cyc);
      end
      checks++;
      if (cell_values !== e.cells) begin
        errors++;
        $display("FAIL %s cells: got %h required %h (cycle %0d)", e.name, cell_values, e.cells, cyc);
      end
      checks++;
      if (digit_segments !== segsOf(e.cells)) begin
        errors++;
        $display("FAIL %s segs: got %h required %h (cycle %0d)", e.name, digit_segments, segsOf(e.cells), cyc);
      end
    end
    if (done || cyc > 5000) begin
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL watchdog: stimulus still running at cycle %0d, required done", cyc);
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: pending=%0d required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin : stim
    logic [3:0] v;
    #1 rst = 1'b0;
    @(negedge clk);
    step(NONE, 4'b0001, 16'h0000, "in_reset");
    @(negedge clk);
    rst = 1'b1;
    step(NONE, 4'b0001, 16'h0000, "reset_state");

    press(R, 4'b0010, 16'h0000, "right1");
    press(R, 4'b0100, 16'h0000, "right2");
    press(R, 4'b1000, 16'h0000, "right3");
    press(R, 4'b0001, 16'h0000, "right_wrap");
    press(L, 4'b1000, 16'h0000, "left_wrap");
    press(L, 4'b0100, 16'h0000, "left_to2");

    for (int k = 1; k <= 10; k++) begin
      v = (k == 10) ? 4'd0 : 4'(k);
      press(I, 4'b0100, {4'h0, v, 8'h00}, "inc_cell2");
    end
    press(D, 4'b0100, 16'h0900, "dec_wrap9");

    loadStep(R, 16'hFA27, 4'b0000, 4'b0001, 16'h0027, "load_sanitize");
    step(R, 4'b0001, 16'h0027, "load_edge_discarded");
    step(NONE, 4'b0001, 16'h0027, "load_edge_release");

    loadStep(NONE, 16'h3050, 4'b1010, 4'b0001, 16'h3050, "load_puzzle");
`ifndef CURSOR_SKIP_LOCKED_EN
    press(R, 4'b0010, 16'h3050, "to_locked");
    press(I, 4'b0010, 16'h3050, "inc_locked");
    press(D, 4'b0010, 16'h3050, "dec_locked");
    press(L, 4'b0001, 16'h3050, "back_to0");
`endif
    step(I, 4'b0001, 16'h3051, "hold_first");
    repeat (49) step(I, 4'b0001, 16'h3051, "hold_no_repeat");
    step(NONE, 4'b0001, 16'h3051, "hold_release");

    press(R | I, RIGHT_FROM0, 16'h3051, "move_beats_edit");
    press(L | R, RIGHT_FROM0, 16'h3051, "left_right_cancel");

    @(negedge clk);
    #2;
    btn_right = 1'b1;
    rst = 1'b0;
    step(R, 4'b0001, 16'h0000, "held_in_reset");
    @(negedge clk);
    rst = 1'b1;
    expectNext(4'b0010, 16'h0000, "held_after_reset");
    step(R, 4'b0010, 16'h0000, "held_once_only");
    step(NONE, 4'b0010, 16'h0000, "held_release");

`ifdef CURSOR_SKIP_LOCKED_EN
    loadStep(NONE, 16'h0000, 4'b0110, 4'b0001, 16'h0000, "skip_load_0110");
    press(R, 4'b1000, 16'h0000, "skip_right");
    press(R, 4'b0001, 16'h0000, "skip_wrap");
    press(L, 4'b1000, 16'h0000, "skip_left_wrap");
    loadStep(NONE, 16'h0000, 4'b0011, 4'b0100, 16'h0000, "skip_load_lowest");
    loadStep(NONE, 16'h0000, 4'b1111, 4'b0001, 16'h0000, "skip_all_locked");
    press(R, 4'b0001, 16'h0000, "skip_all_right");
    press(L, 4'b0001, 16'h0000, "skip_all_left");
`endif

    repeat (2) @(negedge clk);
    done = 1'b1;
  end

endmodule
